// File: rtl/fp_alu_seq_ctrl.sv
// rtl/fp_alu_seq_ctrl.sv - byte-serial opcode/operand sequencer for a 32-bit FP ALU core.
// Optional WAIT timeout with ERR byte enabled by defining ALU_TIMEOUT_EN.
module fp_alu_seq_ctrl #(
    parameter int         TIMEOUT_CYCLES = 64,
    parameter logic [1:0] UNARY_OP       = 2'b11
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  in_byte,
    input  logic        start,
    input  logic [1:0]  opcode,
    output logic [7:0]  out_byte,
    output logic        done,
    output logic [3:0]  state_out,
    output logic [31:0] core_a,
    output logic [31:0] core_b,
    output logic [1:0]  core_op,
    output logic        core_start,
    input  logic        core_valid,
    input  logic [31:0] core_result
);

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        LOAD_A = 4'd1,
        LOAD_B = 4'd2,
        EXEC   = 4'd3,
        WAIT   = 4'd4,
        OUT    = 4'd5,
        ERR    = 4'd6
    } state_t;

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must lie in 2..255");
    end

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] core_a_q, core_a_d;
    logic [31:0] core_b_q, core_b_d;
    logic [1:0]  core_op_q, core_op_d;
    logic        core_start_q, core_start_d;
    logic [31:0] result_q, result_d;
    logic [7:0]  out_byte_q, out_byte_d;
    logic        done_q, done_d;
`ifdef ALU_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0]  tmo_q, tmo_d;
`endif

    function automatic logic [7:0] pick_byte(input logic [31:0] w, input logic [1:0] idx);
        case (idx)
            2'd0:    pick_byte = w[31:24];
            2'd1:    pick_byte = w[23:16];
            2'd2:    pick_byte = w[15:8];
            default: pick_byte = w[7:0];
        endcase
    endfunction

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        core_a_d  = core_a_q;
        core_b_d  = core_b_q;
        core_op_d = core_op_q;
        result_d  = result_q;
`ifdef ALU_TIMEOUT_EN
        tmo_d     = tmo_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    core_op_d = opcode;
                    cnt_d     = 2'd0;
                    state_d   = LOAD_A;
                end
            end
            LOAD_A: begin
                core_a_d = {core_a_q[23:0], in_byte};
                cnt_d    = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    if (core_op_q == UNARY_OP) begin
                        core_b_d = 32'h0;
                        state_d  = EXEC;
                    end else begin
                        state_d  = LOAD_B;
                    end
                end
            end
            LOAD_B: begin
                core_b_d = {core_b_q[23:0], in_byte};
                cnt_d    = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                state_d = WAIT;
`ifdef ALU_TIMEOUT_EN
                tmo_d   = 8'd0;
`endif
            end
            WAIT: begin
                // A valid in the terminal-count cycle takes priority over the timeout.
                if (core_valid) begin
                    result_d = core_result;
                    cnt_d    = 2'd0;
                    state_d  = OUT;
                end
`ifdef ALU_TIMEOUT_EN
                else if (tmo_q == TMO_LAST) begin
                    state_d = ERR;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
`endif
            end
            OUT: begin
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    state_d = IDLE;
                end
            end
            ERR: begin
                state_d = IDLE;
            end
            default: begin
                cnt_d   = 2'd0;
                state_d = IDLE;
            end
        endcase

        // Outputs are registered from the next state so they line up with state_out.
        core_start_d = (state_d == EXEC);
        out_byte_d   = 8'h00;
        done_d       = 1'b0;
        if (state_d == OUT) begin
            out_byte_d = pick_byte(result_d, cnt_d);
            done_d     = 1'b1;
        end else if (state_d == ERR) begin
            out_byte_d = 8'hFF;
            done_d     = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= 2'd0;
            core_a_q     <= 32'h0;
            core_b_q     <= 32'h0;
            core_op_q    <= 2'd0;
            core_start_q <= 1'b0;
            result_q     <= 32'h0;
            out_byte_q   <= 8'h00;
            done_q       <= 1'b0;
`ifdef ALU_TIMEOUT_EN
            tmo_q        <= 8'd0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            core_a_q     <= core_a_d;
            core_b_q     <= core_b_d;
            core_op_q    <= core_op_d;
            core_start_q <= core_start_d;
            result_q     <= result_d;
            out_byte_q   <= out_byte_d;
            done_q       <= done_d;
`ifdef ALU_TIMEOUT_EN
            tmo_q        <= tmo_d;
`endif
        end
    end

    assign state_out  = state_q;
    assign core_a     = core_a_q;
    assign core_b     = core_b_q;
    assign core_op    = core_op_q;
    assign core_start = core_start_q;
    assign out_byte   = out_byte_q;
    assign done       = done_q;

endmodule

// File: tb/tb_fp_alu_seq_ctrl.sv
// tb/tb_fp_alu_seq_ctrl.sv - directed and randomized self-checking bench for fp_alu_seq_ctrl.
module tb_fp_alu_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  in_byte;
    logic        start;
    logic [1:0]  opcode;
    logic [7:0]  out_byte;
    logic        done;
    logic [3:0]  state_out;
    logic [31:0] core_a;
    logic [31:0] core_b;
    logic [1:0]  core_op;
    logic        core_start;
    logic        core_valid;
    logic [31:0] core_result;

    int n_tests = 0;
    int n_fail  = 0;

    fp_alu_seq_ctrl #(.TIMEOUT_CYCLES(8), .UNARY_OP(2'b11)) dut (
        .clk(clk), .rst_n(rst_n), .in_byte(in_byte), .start(start), .opcode(opcode),
        .out_byte(out_byte), .done(done), .state_out(state_out),
        .core_a(core_a), .core_b(core_b), .core_op(core_op), .core_start(core_start),
        .core_valid(core_valid), .core_result(core_result)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Starts in IDLE, accepts the op, streams operands and ends in the first WAIT cycle.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit spur, input bit hold);
        bit unary;
        unary = (op == 2'b11);
        chk("idle_before_start", state_out, 0);
        start  = 1'b1;
        opcode = op;
        step();
        chk("load_a_entry", state_out, 1);
        chk("core_op_capture", core_op, op);
        opcode = ~op;
        for (int i = 0; i < 4; i++) begin
            in_byte = a[31 - 8*i -: 8];
            start   = spur ? 1'($urandom_range(0, 1)) : hold;
            step();
        end
        if (!unary) begin
            chk("load_b_entry", state_out, 2);
            for (int i = 0; i < 4; i++) begin
                in_byte = b[31 - 8*i -: 8];
                start   = hold;
                step();
            end
        end
        chk("exec_state", state_out, 3);
        chk("core_start_pulse", core_start, 1);
        chk("core_a_value", core_a, a);
        chk("core_b_value", core_b, unary ? 32'h0 : b);
        start   = hold;
        in_byte = 8'($urandom);
        if (spur) begin
            core_valid  = 1'b1;
            core_result = ~a;
        end
        step();
        core_valid = 1'b0;
        chk("wait_entry", state_out, 4);
        chk("core_start_single", core_start, 0);
        chk("done_low_in_wait", done, 0);
    endtask

    // Core stub answers after lat idle WAIT cycles; result bytes must come out MSB-first.
    task automatic finish(input logic [31:0] r, input int lat, input bit hold,
                          input logic [31:0] a);
        repeat (lat) step();
        chk("still_waiting", state_out, 4);
        core_valid  = 1'b1;
        core_result = r;
        step();
        core_valid  = 1'b0;
        core_result = $urandom;
        for (int i = 0; i < 4; i++) begin
            chk("out_state", state_out, 5);
            chk("out_byte", out_byte, r[31 - 8*i -: 8]);
            chk("out_done", done, 1);
            start = hold;
            step();
        end
        chk("done_after_out", done, 0);
        chk("out_byte_after_out", out_byte, 0);
        chk("idle_after_out", state_out, 0);
        chk("core_a_stable", core_a, a);
    endtask

    initial begin
        logic [1:0]  op;
        logic [31:0] a, b, r;
        int          bad;

        rst_n       = 1'b0;
        in_byte     = 8'h00;
        start       = 1'b0;
        opcode      = 2'b00;
        core_valid  = 1'b0;
        core_result = 32'h0;
        step();
        step();
        chk("rst_state", state_out, 0);
        chk("rst_out_byte", out_byte, 0);
        chk("rst_done", done, 0);
        chk("rst_core_a", core_a, 0);
        chk("rst_core_b", core_b, 0);
        chk("rst_core_op", core_op, 0);
        chk("rst_core_start", core_start, 0);
        rst_n = 1'b1;
        step();

        // Binary op, core answers 3 cycles after core_start.
        issue(2'b00, 32'h3F800000, 32'h40000000, 1'b0, 1'b0);
        finish(32'h40400000, 2, 1'b0, 32'h3F800000);

        // Unary op: LOAD_B skipped, core_b forced to zero.
        step();
        issue(2'b11, 32'hC0200000, 32'h0, 1'b0, 1'b0);
        finish(32'h40A00000, 1, 1'b0, 32'hC0200000);

        // Back-to-back with start held high; second op accepted in the first IDLE cycle.
        issue(2'b01, 32'h11223344, 32'h55667788, 1'b0, 1'b1);
        finish(32'hDEADBEEF, 0, 1'b1, 32'h11223344);
        issue(2'b10, 32'hA5A5A5A5, 32'h5A5A5A5A, 1'b0, 1'b1);
        finish(32'h01020304, 1, 1'b0, 32'hA5A5A5A5);

        // Spurious valid in EXEC and start toggling during LOAD_A.
        step();
        issue(2'b00, 32'h12345678, 32'h9ABCDEF0, 1'b1, 1'b0);
        finish(32'hCAFEF00D, 2, 1'b0, 32'h12345678);

        // Randomized ops against the byte-split model.
        for (int k = 0; k < 8; k++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            b  = $urandom;
            r  = $urandom;
            issue(op, a, b, 1'($urandom_range(0, 1)), 1'b0);
            finish(r, $urandom_range(0, 5), 1'b0, a);
        end

        // Asynchronous reset after two B bytes.
        start  = 1'b1;
        opcode = 2'b00;
        step();
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            in_byte = 8'($urandom);
            step();
        end
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_state", state_out, 0);
        chk("async_rst_core_a", core_a, 0);
        chk("async_rst_core_b", core_b, 0);
        chk("async_rst_core_op", core_op, 0);
        chk("async_rst_out", {out_byte, 7'b0, done, 7'b0, core_start}, 0);
        step();
        rst_n = 1'b1;
        step();
        issue(2'b10, 32'h0BADF00D, 32'h600DCAFE, 1'b0, 1'b0);
        finish(32'h87654321, 3, 1'b0, 32'h0BADF00D);

        // Core never answers.
        step();
        issue(2'b01, 32'h01010101, 32'h02020202, 1'b0, 1'b0);
`ifdef ALU_TIMEOUT_EN
        repeat (7) step();
        chk("tmo_last_wait", state_out, 4);
        step();
        chk("err_state", state_out, 6);
        chk("err_byte", out_byte, 8'hFF);
        chk("err_done", done, 1);
        step();
        chk("idle_after_err", state_out, 0);
        chk("done_after_err", done, 0);
        chk("out_after_err", out_byte, 0);
`else
        bad = 0;
        for (int i = 0; i < 110; i++) begin
            step();
            if (state_out !== 4'd4 || done !== 1'b0) bad++;
        end
        chk("wait_holds_forever", bad, 0);
        finish(32'h3C3C3C3C, 0, 1'b0, 32'h01010101);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
